// File: rtl/tnn_pkg.sv
// +--------------------------------------------------------------------+
// | tnn_pkg : shared types and defaults for the TNN vote accumulator   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package tnn_pkg;

  localparam int DEF_N_CLASSES       = 7;
  localparam int DEF_VOTES_PER_CLASS = 8;
  localparam int CLS_W               = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/tnn_argmax_step.sv
// +--------------------------------------------------------------------+
// | tnn_argmax_step : one compare-and-select step of the class argmax  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tnn_argmax_step
  import tnn_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] cur_score,
  input  logic [CLS_W-1:0] cur_class,
  input  logic [CNT_W-1:0] cand_score,
  input  logic [CLS_W-1:0] cand_class,
  output logic [CNT_W-1:0] new_score,
  output logic [CLS_W-1:0] new_class
);

  // Strict compare keeps the earlier (lower-index) class on a tie.
  logic w_take;
  assign w_take    = (cand_score > cur_score);
  assign new_score = w_take ? cand_score : cur_score;
  assign new_class = w_take ? cand_class : cur_class;

endmodule

`default_nettype wire

// File: rtl/tnn_vote_accum.sv
// +--------------------------------------------------------------------+
// | tnn_vote_accum : per-class popcount of neuron votes and argmax     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tnn_vote_accum
  import tnn_pkg::*;
#(
  parameter int N_CLASSES       = DEF_N_CLASSES,
  parameter int VOTES_PER_CLASS = DEF_VOTES_PER_CLASS,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_vote,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CLS_W-1:0] out_class,
  output logic [CNT_W-1:0] out_score,
  output logic             out_err
);

  localparam int VIDX_W = (VOTES_PER_CLASS > 1) ? $clog2(VOTES_PER_CLASS) : 1;
  localparam logic [VIDX_W-1:0] C_LAST_VOTE  = VIDX_W'(VOTES_PER_CLASS - 1);
  localparam logic [CLS_W-1:0]  C_LAST_CLASS = CLS_W'(N_CLASSES - 1);

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [VIDX_W-1:0]  vote_idx_q, vote_idx_d;
  logic [CLS_W-1:0]   class_idx_q, class_idx_d;
  logic [CNT_W-1:0]   class_score_q, class_score_d;
  logic [CNT_W-1:0]   best_score_q, best_score_d;
  logic [CLS_W-1:0]   best_class_q, best_class_d;
  logic [CLS_W-1:0]   out_class_q, out_class_d;
  logic [CNT_W-1:0]   out_score_q, out_score_d;
  logic               out_err_q, out_err_d;

  logic               w_accept;
  logic               w_final_beat;
  logic               w_go_decide;
  logic [CNT_W-1:0]   w_score_inc;
  logic [CNT_W-1:0]   w_cand_score;
  logic [CNT_W-1:0]   w_fold_score;
  logic [CLS_W-1:0]   w_fold_class;

  assign w_accept     = in_valid & in_ready_q;
  assign w_final_beat = (class_idx_q == C_LAST_CLASS) && (vote_idx_q == C_LAST_VOTE);
  assign w_go_decide  = w_accept && (in_last || w_final_beat);
  assign w_score_inc  = class_score_q + CNT_W'(in_vote);

  // Beats are never accepted in DECIDE, so one argmax serves both the
  // end-of-class fold (with the incoming vote) and the final partial fold.
  assign w_cand_score = (state_q == ST_DECIDE) ? class_score_q : w_score_inc;

  tnn_argmax_step #(
    .CNT_W(CNT_W)
  ) u_argmax (
    .cur_score  (best_score_q),
    .cur_class  (best_class_q),
    .cand_score (w_cand_score),
    .cand_class (class_idx_q),
    .new_score  (w_fold_score),
    .new_class  (w_fold_class)
  );

  always_comb begin
    state_d       = state_q;
    vote_idx_d    = vote_idx_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    best_score_d  = best_score_q;
    best_class_d  = best_class_q;
    out_class_d   = out_class_q;
    out_score_d   = out_score_q;
    out_err_d     = out_err_q;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (w_go_decide) begin
          class_score_d = w_score_inc;
          out_err_d     = in_last ^ w_final_beat;
          state_d       = ST_DECIDE;
        end else if (w_accept) begin
          state_d = ST_ACCUM;
          if (vote_idx_q == C_LAST_VOTE) begin
            vote_idx_d    = '0;
            class_idx_d   = class_idx_q + CLS_W'(1);
            class_score_d = '0;
            best_score_d  = w_fold_score;
            best_class_d  = w_fold_class;
          end else begin
            vote_idx_d    = vote_idx_q + VIDX_W'(1);
            class_score_d = w_score_inc;
          end
        end
      end
      ST_DECIDE: begin
        out_class_d = w_fold_class;
        out_score_d = w_fold_score;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          vote_idx_d    = '0;
          class_idx_d   = '0;
          class_score_d = '0;
          best_score_d  = '0;
          best_class_d  = '0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake flags are registered from the next state so reset can
    // hold them low while the FSM itself already sits in IDLE.
    in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      vote_idx_q    <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      best_score_q  <= '0;
      best_class_q  <= '0;
      out_class_q   <= '0;
      out_score_q   <= '0;
      out_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      vote_idx_q    <= vote_idx_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      best_score_q  <= best_score_d;
      best_class_q  <= best_class_d;
      out_class_q   <= out_class_d;
      out_score_q   <= out_score_d;
      out_err_q     <= out_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_score = out_score_q;
  assign out_err   = out_err_q;

endmodule

`default_nettype wire

// File: tb/tb_tnn_vote_accum.sv
// +--------------------------------------------------------------------+
// | tb_tnn_vote_accum : directed self-checking bench for vote accum    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_tnn_vote_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_vote;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_class;
  logic [3:0] out_score;
  logic       out_err;

  int checks = 0;
  int errors = 0;
  logic [55:0] v;

  always #5 clk = ~clk;

  tnn_vote_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vote   (in_vote),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic beat(input logic vote, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_vote  = vote;
    in_last  = last;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("beat_ready_timeout", 32'(guard < 20), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vote  = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_inf(input logic [55:0] votes, input int last_at, input int n_beats);
    logic [55:0] vv;
    vv = votes;
    for (int i = 0; i < n_beats; i++) begin
      beat(vv[i], (i + 1) == last_at);
    end
  endtask

  task automatic wait_result();
    int guard = 0;
    while (out_valid !== 1'b1 && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    check("result_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int cls, input int score, input int err);
    check({tag, "_class"}, 32'(out_class), 32'(cls));
    check({tag, "_score"}, 32'(out_score), 32'(score));
    check({tag, "_err"},   32'(out_err),   32'(err));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vote   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    expect_result("rst", 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_ready", 32'(in_ready), 32'd1);

    // Class 3 all ones, in_last on beat 56, latency check
    v = '0;
    v[31:24] = 8'hFF;
    run_inf(v, 56, 56);
    check("lat_decide_valid", 32'(out_valid), 32'd0);
    check("lat_decide_ready", 32'(in_ready),  32'd0);
    @(posedge clk); #1;
    check("lat_hold_valid", 32'(out_valid), 32'd1);
    expect_result("c3", 3, 8, 0);
    release_result();
    check("c3_idle_ready", 32'(in_ready),  32'd1);
    check("c3_idle_valid", 32'(out_valid), 32'd0);

    // Tie between classes 1 and 4 at 6 resolves to class 1
    v = '0;
    v[7:0]   = 8'h1F;
    v[15:8]  = 8'h3F;
    v[23:16] = 8'h07;
    v[39:32] = 8'h3F;
    v[55:48] = 8'h1F;
    run_inf(v, 56, 56);
    wait_result();
    expect_result("tie", 1, 6, 0);
    release_result();

    // All votes zero
    v = '0;
    run_inf(v, 56, 56);
    wait_result();
    expect_result("zero", 0, 0, 0);
    release_result();

    // Early in_last at beat 20: partial class 2 (4) beats class 1 (3)
    v = '0;
    v[15:8]  = 8'h07;
    v[19:16] = 4'hF;
    run_inf(v, 20, 20);
    check("early_decide_ready", 32'(in_ready), 32'd0);
    wait_result();
    expect_result("early", 2, 4, 1);
    release_result();

    // Final expected beat without in_last; last class wins
    v = '0;
    v[55:48] = 8'hFF;
    run_inf(v, 0, 56);
    wait_result();
    expect_result("nolast", 6, 8, 1);
    release_result();

    // Back-pressure: result held for 5 cycles with a beat pending
    v = '0;
    v[46:40] = 7'h7F;
    run_inf(v, 56, 56);
    wait_result();
    in_valid = 1'b1;
    in_vote  = 1'b1;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_ready", 32'(in_ready),  32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      expect_result("hold", 5, 7, 0);
    end
    in_valid = 1'b0;
    in_vote  = 1'b0;
    in_last  = 1'b0;
    release_result();
    check("hold_rel_ready", 32'(in_ready),  32'd1);
    check("hold_rel_valid", 32'(out_valid), 32'd0);
    v = '0;
    v[23:16] = 8'hFF;
    run_inf(v, 56, 56);
    wait_result();
    expect_result("after_hold", 2, 8, 0);
    release_result();

    // Reset pulse mid-ACCUM after 30 beats discards the inference
    v = '1;
    run_inf(v, 0, 30);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(in_ready),  32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    check("midrst_ready_back", 32'(in_ready), 32'd1);
    v = '0;
    v[1:0] = 2'b11;
    run_inf(v, 56, 56);
    wait_result();
    expect_result("after_rst", 0, 2, 0);
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
